// File: rtl/snes_poll_engine.sv
// Polls a SNES/NES-style serial pad (latch/clock/data) and presents the inverted button word.
// Latency: poll_start to buttons_vld = 3*HALF_DIV + (NUM_BITS-1)*2*HALF_DIV + 2 PCLK cycles.
// No backpressure: buttons_vld is a one-cycle strobe; poll_start is dropped while busy.
module snes_poll_engine #(
    parameter int HALF_DIV = 200,
    parameter int NUM_BITS = 16,
    parameter int POLL_GAP = 16000
) (
    input  logic                PCLK,
    input  logic                PRESERN,
    input  logic                poll_start,
    input  logic                auto_en,
    input  logic                cont_data,
    output logic                cont_latch,
    output logic                cont_clk,
    output logic [NUM_BITS-1:0] buttons,
    output logic                buttons_vld,
    output logic                busy
);

    localparam int PH_W  = $clog2(2 * HALF_DIV);
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF_DIV - 1);
    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 2);
    // Loaded in DONE so that the count hits 1 on the last IDLE cycle before the restart.
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(POLL_GAP - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_GAP0   = 3'd2;
    localparam logic [2:0] ST_CLK_LO = 3'd3;
    localparam logic [2:0] ST_CLK_HI = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]          state;
    logic [2:0]          stateNxt;
    logic [PH_W-1:0]     phase;
    logic [BIT_W-1:0]    bitCnt;
    logic [NUM_BITS-1:0] shreg;
    logic [GAP_W-1:0]    gapCnt;
    logic [1:0]          dataSync;
    logic                phaseEnd;
    logic                sampleNow;
    logic                gapExpired;

    // Dwell decode, sample strobe and next-state selection.
    always_comb begin
        phaseEnd   = (state == ST_LATCH) ? (phase == LATCH_LAST) : (phase == HALF_LAST);
        sampleNow  = phaseEnd && ((state == ST_GAP0) || (state == ST_CLK_HI));
        gapExpired = (state == ST_IDLE) && auto_en && (gapCnt == GAP_W'(1));
        stateNxt   = state;
        case (state)
            ST_IDLE:   if ((poll_start && !busy) || gapExpired) stateNxt = ST_LATCH;
            ST_LATCH:  if (phaseEnd) stateNxt = ST_GAP0;
            ST_GAP0:   if (phaseEnd) stateNxt = ST_CLK_LO;
            ST_CLK_LO: if (phaseEnd) stateNxt = ST_CLK_HI;
            ST_CLK_HI: if (phaseEnd) stateNxt = (bitCnt == BIT_LAST) ? ST_DONE : ST_CLK_LO;
            ST_DONE:   stateNxt = ST_IDLE;
            default:   stateNxt = ST_IDLE;
        endcase
    end

    // Sequencer: state, phase counter (restarts on every state entry) and bit-pair counter.
    always_ff @(posedge PCLK) begin
        if (PRESERN) begin
            state  <= ST_IDLE;
            phase  <= '0;
            bitCnt <= '0;
        end else begin
            state <= stateNxt;
            if (stateNxt != state)
                phase <= '0;
            else if ((state != ST_IDLE) && (state != ST_DONE))
                phase <= phase + 1'b1;
            if (state == ST_IDLE)
                bitCnt <= '0;
            else if ((state == ST_CLK_HI) && phaseEnd && (bitCnt != BIT_LAST))
                bitCnt <= bitCnt + 1'b1;
        end
    end

    // Pad data synchronizer and LSB-first shift register; first sample ends up in bit 0.
    always_ff @(posedge PCLK) begin
        if (PRESERN) begin
            dataSync <= '1;
            shreg    <= '0;
        end else begin
            dataSync <= {dataSync[0], cont_data};
            if (sampleNow)
                shreg <= {dataSync[1], shreg[NUM_BITS-1:1]};
        end
    end

    // Auto-repoll gap counter: armed by DONE, runs down in IDLE, parked at 0 when auto is off.
    always_ff @(posedge PCLK) begin
        if (PRESERN || !auto_en)
            gapCnt <= '0;
        else if (state == ST_DONE)
            gapCnt <= GAP_LOAD;
        else if ((state == ST_IDLE) && (gapCnt != '0))
            gapCnt <= gapCnt - 1'b1;
    end

    // Registered outputs decoded from the current state; buttons only change after DONE.
    always_ff @(posedge PCLK) begin
        if (PRESERN) begin
            cont_latch  <= 1'b0;
            cont_clk    <= 1'b1;
            buttons     <= '0;
            buttons_vld <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cont_latch  <= (state == ST_LATCH);
            cont_clk    <= (state != ST_CLK_LO);
            buttons_vld <= (state == ST_DONE);
            busy        <= (state != ST_IDLE);
            if (state == ST_DONE)
                buttons <= ~shreg;
        end
    end

endmodule
